// File: rtl/slime_hit_detect.sv
// slime_hit_detect: frame-sampled player/slime hitbox overlap with one-shot damage pulse and cooldown.
// Optional macro SLIME_HIT_EDGE_EN: fire only on newly started overlaps.
module slime_hit_detect #(
   parameter int PLAYER_W        = 32,
   parameter int PLAYER_H        = 32,
   parameter int SLIME_W         = 24,
   parameter int SLIME_H         = 16,
   parameter int COOLDOWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [9:0] player_x,
   input  logic [8:0] player_y,
   input  logic [9:0] slime0_x,
   input  logic [8:0] slime0_y,
   input  logic [9:0] slime1_x,
   input  logic [8:0] slime1_y,
   input  logic [1:0] slime_alive,
   output logic [1:0] slim_damage,
   output logic       cooldown_active
);
   typedef enum logic [1:0] {IDLE, SAMPLE, FIRE, COOLDOWN} state_t;
   state_t state, state_nx;
   logic [9:0] px, sx0, sx1;
   logic [8:0] py, sy0, sy1;
   logic [1:0] alive, ovl, new_ovl, fire;
   logic [7:0] cnt;

   // widened compares so boxes near the right/bottom edge never wrap
   function automatic logic hit(input logic [9:0] ax, input logic [8:0] ay,
                                input logic [9:0] bx, input logic [8:0] by);
      hit = ({1'b0, ax} < {1'b0, bx} + 11'(SLIME_W)) && ({1'b0, bx} < {1'b0, ax} + 11'(PLAYER_W)) &&
            ({1'b0, ay} < {1'b0, by} + 10'(SLIME_H)) && ({1'b0, by} < {1'b0, ay} + 10'(PLAYER_H));
   endfunction

   assign ovl = alive & {hit(px, py, sx1, sy1), hit(px, py, sx0, sy0)};

`ifdef SLIME_HIT_EDGE_EN
   logic [1:0] prev;
   assign new_ovl = ovl & ~prev;
   always_ff @(posedge clk or posedge reset)
      if (reset) prev <= '0;
      else if (state == SAMPLE) prev <= ovl;
      else if (state == COOLDOWN && frame_tick)
         prev <= slime_alive & {hit(player_x, player_y, slime1_x, slime1_y),
                                hit(player_x, player_y, slime0_x, slime0_y)};
`else
   assign new_ovl = ovl;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     state_nx = frame_tick ? SAMPLE : IDLE;
         SAMPLE:   state_nx = |new_ovl ? FIRE : IDLE;
         FIRE:     state_nx = COOLDOWN;
         COOLDOWN: state_nx = (frame_tick && cnt <= 8'd1) ? IDLE : COOLDOWN;
      endcase
   end

   always_comb begin
      slim_damage     = state == FIRE ? fire : 2'b00;
      cooldown_active = state == COOLDOWN;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {px, py, sx0, sy0, sx1, sy1} <= '0;
         alive <= '0;
         fire  <= '0;
         cnt   <= '0;
      end else begin
         if (state == IDLE && frame_tick) begin
            px    <= player_x;
            py    <= player_y;
            sx0   <= slime0_x;
            sy0   <= slime0_y;
            sx1   <= slime1_x;
            sy1   <= slime1_y;
            alive <= slime_alive;
         end
         if (state == SAMPLE) fire <= new_ovl;
         if (state == FIRE) cnt <= 8'(COOLDOWN_FRAMES);
         else if (state == COOLDOWN && frame_tick) cnt <= cnt - 8'd1;
      end
endmodule
